// File: rtl/parity_frame_checker.sv
// Receive-side serial parity checker: deserialises DATA_BITS data bits (LSB first)
// plus one parity bit, then reports the word, a parity-error flag and a saturating error count.
module parity_frame_checker #(
    parameter int DATA_BITS  = 8,
    parameter bit ODD_PARITY = 1'b1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 x,
    input  logic                 valid,
    input  logic                 start,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_done,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic                 run_par;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 take_first;
    logic                 take_bit;
    logic                 take_parity;
    logic                 bad_parity;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A qualified start always begins a new frame, silently dropping any partial one.
    always_comb begin
        state_next  = state;
        take_first  = 1'b0;
        take_bit    = 1'b0;
        take_parity = 1'b0;
        if (valid) begin
            if (start) begin
                take_first = 1'b1;
                state_next = (DATA_BITS == 1) ? PARITY : DATA;
            end else begin
                case (state)
                    DATA: begin
                        take_bit = 1'b1;
                        if (cnt == CNT_W'(DATA_BITS - 1)) begin
                            state_next = PARITY;
                        end
                    end
                    PARITY: begin
                        take_parity = 1'b1;
                        state_next  = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        shift_next = shift_reg;
        for (int i = 0; i < DATA_BITS; i++) begin
            if (cnt == CNT_W'(i)) begin
                shift_next[i] = x;
            end
        end
    end

    // Expected parity bit is run_par for even parity and its inverse for odd parity.
    assign bad_parity = x != (run_par ^ ODD_PARITY);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            run_par    <= 1'b0;
            shift_reg  <= '0;
            data_out   <= '0;
            frame_done <= 1'b0;
            parity_err <= 1'b0;
            err_count  <= '0;
        end else begin
            frame_done <= 1'b0;
            if (take_first) begin
                shift_reg <= DATA_BITS'(x);
                run_par   <= x;
                cnt       <= CNT_W'(1);
            end else if (take_bit) begin
                shift_reg <= shift_next;
                run_par   <= run_par ^ x;
                cnt       <= cnt + CNT_W'(1);
            end else if (take_parity) begin
                data_out   <= shift_reg;
                parity_err <= bad_parity;
                frame_done <= 1'b1;
                cnt        <= '0;
                run_par    <= 1'b0;
                if (bad_parity && (err_count != '1)) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign busy = (state == DATA) || (state == PARITY);

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them whenever frame_done is seen.
module tb_parity_frame_checker;

    localparam int DATA_BITS  = 8;
    localparam bit ODD_PARITY = 1'b1;
    localparam int ERR_CNT_W  = 2;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b0;
    logic                 x     = 1'b0;
    logic                 valid = 1'b0;
    logic                 start = 1'b0;
    logic                 busy;
    logic [DATA_BITS-1:0] data_out;
    logic                 frame_done;
    logic                 parity_err;
    logic [ERR_CNT_W-1:0] err_count;

    parity_frame_checker #(
        .DATA_BITS (DATA_BITS),
        .ODD_PARITY(ODD_PARITY),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .valid     (valid),
        .start     (start),
        .busy      (busy),
        .data_out  (data_out),
        .frame_done(frame_done),
        .parity_err(parity_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        logic                 perr;
        logic [ERR_CNT_W-1:0] cnt;
        int                   edge_no;
    } exp_t;

    exp_t                 sb[$];
    int                   tests_run    = 0;
    int                   tests_failed = 0;
    logic [ERR_CNT_W-1:0] model_cnt    = '0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic send_bit(input logic b, input logic st);
        x     = b;
        start = st;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        start = 1'b0;
        x     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame; exp_perr is the hand-computed parity verdict for (d, p).
    task automatic apply_stimulus(input logic [DATA_BITS-1:0] d, input logic p,
                                  input logic exp_perr, input int gap_mid, input int gap_par);
        exp_t e;
        if (exp_perr && (model_cnt != '1)) model_cnt = model_cnt + 1'b1;
        e.data    = d;
        e.perr    = exp_perr;
        e.cnt     = model_cnt;
        e.edge_no = cyc + 1 + DATA_BITS + gap_mid + gap_par;
        sb.push_back(e);
        for (int i = 0; i < DATA_BITS; i++) begin
            send_bit(d[i], i == 0);
            if (i == 2) idle(gap_mid);
            if (i == DATA_BITS - 1) idle(gap_par);
        end
        send_bit(p, 1'b0);
    endtask

    always @(negedge clk) begin
        if (reset && frame_done) begin
            if (sb.size() == 0) begin
                check_output("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("done_cycle", 32'(cyc), 32'(e.edge_no));
                check_output("data_out", 32'(data_out), 32'(e.data));
                check_output("parity_err", 32'(parity_err), 32'(e.perr));
                check_output("err_count", 32'(err_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        reset = 1'b0;
        idle(2);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_data_out", 32'(data_out), 32'd0);
        check_output("rst_frame_done", 32'(frame_done), 32'd0);
        check_output("rst_parity_err", 32'(parity_err), 32'd0);
        check_output("rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b1;
        idle(2);

        apply_stimulus(8'hA5, 1'b1, 1'b0, 0, 0);
        idle(2);
        apply_stimulus(8'hA5, 1'b0, 1'b1, 0, 0);
        idle(2);
        apply_stimulus(8'h01, 1'b0, 1'b0, 0, 0);
        idle(2);
        apply_stimulus(8'h3C, 1'b1, 1'b0, 3, 3);
        idle(2);

        // Aborted partial frame followed by a restart.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check_output("busy_mid_frame", 32'(busy), 32'd1);
        apply_stimulus(8'hFF, 1'b1, 1'b0, 0, 0);
        idle(2);
        check_output("busy_after_frame", 32'(busy), 32'd0);

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
        reset = 1'b0;
        idle(1);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_data_out", 32'(data_out), 32'd0);
        check_output("midrst_frame_done", 32'(frame_done), 32'd0);
        check_output("midrst_parity_err", 32'(parity_err), 32'd0);
        check_output("midrst_err_count", 32'(err_count), 32'd0);
        model_cnt = '0;
        reset     = 1'b1;
        idle(1);
        apply_stimulus(8'h80, 1'b0, 1'b0, 0, 0);
        idle(2);

        // Back-to-back bad frames drive the 2-bit counter into saturation.
        for (int k = 0; k < 5; k++) apply_stimulus(8'h00, 1'b0, 1'b1, 0, 0);

        for (int t = 0; t < 20 && sb.size() != 0; t++) idle(1);
        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
        idle(2);
        check_output("final_err_count", 32'(err_count), 32'd3);
        check_output("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
